// File: rtl/direct_mapped_cache_if.sv
// Access bus for the direct-mapped tag cache.
// Master drives Data_in; slave returns Data_output (hit flag) and hits.
interface direct_mapped_cache_if #(
    parameter int ADDR_W = 32,
    parameter int HIT_W  = 21
);
    logic [ADDR_W-1:0] Data_in;
    logic              Data_output;
    logic [HIT_W-1:0]  hits;

    modport master (
        output Data_in,
        input  Data_output,
        input  hits
    );

    modport slave (
        input  Data_in,
        output Data_output,
        output hits
    );
endinterface

// File: rtl/direct_mapped_cache.sv
// Direct-mapped tag-only cache: one lookup per clock, allocate on miss.
// Ports: clk, rst_n (async low), bus.slave (Data_in, Data_output, hits).
module direct_mapped_cache #(
    parameter int ADDR_W      = 32,
    parameter int OFFSET_BITS = 4,
    parameter int INDEX_BITS  = 10,
    parameter int HIT_W       = 21
) (
    input  logic                  clk,
    input  logic                  rst_n,
    direct_mapped_cache_if.slave  bus
);
    localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int LINES = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic                  unused_offset;

    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tag_mem [LINES];

    logic                  hit_q;
    logic [HIT_W-1:0]      hits_q;

    assign index = bus.Data_in[OFFSET_BITS +: INDEX_BITS];
    assign tag   = bus.Data_in[ADDR_W-1 -: TAG_W];
    assign unused_offset = ^bus.Data_in[OFFSET_BITS-1:0];

    assign hit = valid[index] && (tag_mem[index] == tag);

    // Valid bits and counters reset; tags are qualified by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= '0;
            hit_q  <= 1'b0;
            hits_q <= '0;
        end else begin
            hit_q <= hit;
            if (hit) begin
                if (hits_q != '1) begin
                    hits_q <= hits_q + 1'b1;
                end
            end else begin
                valid[index] <= 1'b1;
            end
        end
    end

    // No reset on the tag array so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!hit) begin
            tag_mem[index] <= tag;
        end
    end

    assign bus.Data_output = hit_q;
    assign bus.hits        = hits_q;
endmodule

// File: tb/tb_direct_mapped_cache.sv
// Scoreboard bench for direct_mapped_cache.
// Main instance at default sizes; a narrow-counter instance for saturation.
module tb_direct_mapped_cache;
    localparam int HW    = 21;
    localparam int SAT_W = 4;
    localparam int SAT_MAX = (1 << SAT_W) - 1;
    localparam int MAX = (1 << HW) - 1;

    typedef struct {
        logic          hit;
        logic [HW-1:0] hits;
    } exp_t;

    logic clk;
    logic rst_n;

    direct_mapped_cache_if #(.ADDR_W(32), .HIT_W(HW))    m_if ();
    direct_mapped_cache_if #(.ADDR_W(32), .HIT_W(SAT_W)) s_if ();

    direct_mapped_cache dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if.slave)
    );

    direct_mapped_cache #(.HIT_W(SAT_W)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    exp_t q[$];
    bit          mvalid [1024];
    logic [17:0] mtag   [1024];
    int          mhits;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference lookup: returns hit and updates model state.
    task automatic drive(input logic [31:0] a);
        exp_t e;
        int idx;
        logic [17:0] t;
        idx = int'(a[13:4]);
        t = a[31:14];
        m_if.Data_in = a;
        if (mvalid[idx] && mtag[idx] == t) begin
            e.hit = 1'b1;
            if (mhits != MAX) mhits++;
        end else begin
            e.hit = 1'b0;
            mvalid[idx] = 1'b1;
            mtag[idx] = t;
        end
        e.hits = HW'(mhits);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Async reset pulse placed mid-cycle so no edge is lost.
    task automatic do_reset(input string nm);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (m_if.Data_output !== 1'b0 || m_if.hits !== '0) begin
            n_err++;
            $display("FAIL %s_async: out=%b hits=%0d want 0/0",
                     nm, m_if.Data_output, m_if.hits);
        end
        for (int i = 0; i < 1024; i++) mvalid[i] = 1'b0;
        mhits = 0;
        q.delete();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset("reset");
        drive(32'h0000_0000);
        e = q.pop_front();
        n_cmp++;
        if (m_if.Data_output !== 1'b0 || m_if.hits !== 21'd0
            || e.hit !== 1'b0) begin
            n_err++;
            $display("FAIL cold_miss: out=%b hits=%0d want 0/0",
                     m_if.Data_output, m_if.hits);
        end
    endtask

    task automatic test_same_block();
        exp_t e;
        do_reset("same_blk");
        drive(32'h0000_0000);
        drive(32'h0000_000C);
        void'(q.pop_front());
        e = q.pop_front();
        n_cmp++;
        if (m_if.Data_output !== 1'b1 || m_if.hits !== 21'd1
            || e.hit !== 1'b1) begin
            n_err++;
            $display("FAIL same_block: out=%b hits=%0d want 1/1",
                     m_if.Data_output, m_if.hits);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] seq [3];
        exp_t e;
        seq[0] = 32'h0000_0000;
        seq[1] = 32'h0000_4000;
        seq[2] = 32'h0000_0000;
        do_reset("conflict");
        for (int i = 0; i < 3; i++) begin
            drive(seq[i]);
            e = q.pop_front();
            n_cmp++;
            if (m_if.Data_output !== 1'b0 || m_if.hits !== 21'd0
                || e.hit !== 1'b0) begin
                n_err++;
                $display("FAIL conflict[%0d]: out=%b hits=%0d want 0/0",
                         i, m_if.Data_output, m_if.hits);
            end
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        int bad;
        do_reset("sweep");
        for (int p = 0; p < 2; p++) begin
            bad = 0;
            for (int k = 0; k < 1024; k++) begin
                drive(32'(k * 16));
                e = q.pop_front();
                if (m_if.Data_output !== logic'(p)
                    || m_if.hits !== e.hits) begin
                    if (bad == 0)
                        $display("FAIL sweep_p%0d k=%0d: out=%b hits=%0d want %0d/%0d",
                                 p, k, m_if.Data_output, m_if.hits, p, e.hits);
                    bad++;
                end
            end
            n_cmp++;
            if (bad != 0) n_err++;
        end
        n_cmp++;
        if (m_if.hits !== 21'd1024) begin
            n_err++;
            $display("FAIL sweep_total: hits=%0d want 1024", m_if.hits);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        do_reset("mid_pre");
        for (int k = 0; k < 8; k++) drive(32'(k * 16));
        for (int k = 0; k < 8; k++) drive(32'(k * 16));
        q.delete();
        n_cmp++;
        if (m_if.hits !== 21'd8) begin
            n_err++;
            $display("FAIL mid_pre: hits=%0d want 8", m_if.hits);
        end
        do_reset("mid_rst");
        drive(32'h0000_0030);
        e = q.pop_front();
        n_cmp++;
        if (m_if.Data_output !== 1'b0 || m_if.hits !== 21'd0
            || e.hit !== 1'b0) begin
            n_err++;
            $display("FAIL mid_replay: out=%b hits=%0d want 0/0",
                     m_if.Data_output, m_if.hits);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pool [6];
        exp_t e;
        pool[0] = 32'h0000_0100;
        pool[1] = 32'h0000_4100;
        pool[2] = 32'h1234_5678;
        pool[3] = 32'hFFFF_FFF0;
        pool[4] = 32'h0000_0104;
        pool[5] = 32'h8000_3FF0;
        do_reset("b2b");
        for (int i = 0; i < 200; i++) begin
            drive(pool[$urandom_range(0, 5)]);
            e = q.pop_front();
            n_cmp++;
            if (m_if.Data_output !== e.hit || m_if.hits !== e.hits) begin
                n_err++;
                $display("FAIL b2b[%0d]: out=%b hits=%0d want %b/%0d",
                         i, m_if.Data_output, m_if.hits, e.hit, e.hits);
            end
        end
    endtask

    task automatic test_saturation();
        int sq[$];
        int want;
        s_if.Data_in = 32'h0000_0040;
        do_reset("sat");
        for (int i = 0; i < 25; i++) begin
            sq.push_back(i < SAT_MAX ? i : SAT_MAX);
            @(posedge clk);
            #1;
            want = sq.pop_front();
            n_cmp++;
            if (s_if.hits !== SAT_W'(want)
                || s_if.Data_output !== (i != 0)) begin
                n_err++;
                $display("FAIL sat[%0d]: hits=%0d out=%b want %0d/%b",
                         i, s_if.hits, s_if.Data_output, want, i != 0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        m_if.Data_in = '0;
        s_if.Data_in = '0;
        mhits = 0;
        #1;
        test_reset();
        test_same_block();
        test_conflict();
        test_sweep();
        test_mid_reset();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
